// File: rtl/ramif_banked_if.sv
// Bus bundle for the banked sample memory: access request, write data,
// read return and clear handshake. The slave side is the memory wrapper.
interface ramif_banked_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 5,
    parameter int GROUPS = 4
);
    logic              en_i;
    logic              we_i;
    logic [GROUPS-1:0] be_i;
    logic [DEPTH-1:0]  addr_i;
    logic [WIDTH-1:0]  d_i;
    logic [WIDTH-1:0]  d_o;
    logic              valid_o;
    logic              clr_i;
    logic              busy_o;

    // Sampler / readback controller side.
    modport master (
        output en_i, we_i, be_i, addr_i, d_i, clr_i,
        input  d_o, valid_o, busy_o
    );

    // Memory wrapper side.
    modport slave (
        input  en_i, we_i, be_i, addr_i, d_i, clr_i,
        output d_o, valid_o, busy_o
    );
endinterface

// File: rtl/ramif_banked.sv
// Single-port sample memory for the capture path. Behaviourally inferred
// array with per-channel-group write enables, 1- or 2-cycle registered read
// with a valid strobe, and a clear engine that fills every entry with
// CLEAR_VAL after reset or on request. Accesses are dropped while clearing.
module ramif_banked #(
    parameter int               WIDTH          = 32,
    parameter int               DEPTH          = 5,
    parameter int               GROUP_W        = 8,
    parameter int               READ_LAT       = 1,
    parameter int               CLEAR_ON_RESET = 1,
    parameter logic [WIDTH-1:0] CLEAR_VAL      = '0,
    parameter                   RAM_STYLE      = "distributed"
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ramif_banked_if.slave bus
);

    localparam int GROUPS  = WIDTH / GROUP_W;
    localparam int ENTRIES = 2 ** DEPTH;

    // Configuration sanity checks, reported at elaboration.
    if (WIDTH % GROUP_W != 0) begin : g_err_width
        $error("ramif_banked: WIDTH (%0d) must be a multiple of GROUP_W (%0d)", WIDTH, GROUP_W);
    end
    if (READ_LAT != 1 && READ_LAT != 2) begin : g_err_lat
        $error("ramif_banked: READ_LAT (%0d) must be 1 or 2", READ_LAT);
    end
    if (RAM_STYLE != "distributed" && RAM_STYLE != "block") begin : g_err_style
        $error("ramif_banked: RAM_STYLE must be \"distributed\" or \"block\"");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [DEPTH-1:0] ptr_q;
    logic [DEPTH-1:0] ptr_d;

    // Unified write port: either a masked user write or a clear-engine fill.
    logic              wr_en;
    logic [GROUPS-1:0] wr_be;
    logic [DEPTH-1:0]  wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_req;

    // NOTE: the array has no reset; clearing it is the job of the sweep, and a
    // reset term here would stop the tools from mapping it onto RAM primitives.
    (* ram_style = RAM_STYLE *) logic [WIDTH-1:0] mem [ENTRIES];

    // First read stage: the registered array output.
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    // Next-state and access decode; clear takes priority over any access.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        wr_be   = '0;
        wr_addr = bus.addr_i;
        wr_data = bus.d_i;
        rd_req  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.clr_i) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end else if (bus.en_i) begin
                    if (bus.we_i) begin
                        wr_en = 1'b1;
                        wr_be = bus.be_i;
                    end else begin
                        rd_req = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_be   = '1;
                wr_addr = ptr_q;
                wr_data = CLEAR_VAL;
                ptr_d   = ptr_q + 1'b1;
                if (ptr_q == DEPTH'(ENTRIES - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and clear pointer registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Array write port with per-group byte-lane style enables.
    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) begin
            for (int g = 0; g < GROUPS; g++) begin
                if (wr_be[g]) begin
                    mem[wr_addr][g*GROUP_W +: GROUP_W] <= wr_data[g*GROUP_W +: GROUP_W];
                end
            end
        end
    end

    // Registered array read; data holds until the next accepted read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_req;
            if (rd_req) begin
                rd_data_q <= mem[bus.addr_i];
            end
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic [WIDTH-1:0] out_data_q;
        logic             out_valid_q;

        // Extra output register stage, fully pipelined behind the array read.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                out_data_q  <= '0;
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= rd_valid_q;
                if (rd_valid_q) begin
                    out_data_q <= rd_data_q;
                end
            end
        end

        assign bus.d_o     = out_data_q;
        assign bus.valid_o = out_valid_q;
    end else begin : g_lat1
        assign bus.d_o     = rd_data_q;
        assign bus.valid_o = rd_valid_q;
    end

    assign bus.busy_o = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ramif_banked.sv
// Self-checking bench for ramif_banked. Three instances share one stimulus
// stream: (A) READ_LAT=1 with clear-on-reset, (B) READ_LAT=2 with
// clear-on-reset, (C) READ_LAT=1 without clear-on-reset. A behavioural model
// tracks memory contents, the sweep and scheduled read returns per instance.
module tb_ramif_banked;

    localparam int W  = 32;
    localparam int D  = 5;
    localparam int GW = 8;
    localparam int G  = W / GW;
    localparam int N  = 2 ** D;
    localparam logic [W-1:0] CV_A = 32'hA5A5_A5A5;
    localparam logic [W-1:0] CV_B = 32'h0000_0000;
    localparam logic [W-1:0] CV_C = 32'h0F0F_F0F0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared stimulus
    logic         s_en, s_we, s_clr;
    logic [G-1:0] s_be;
    logic [D-1:0] s_addr;
    logic [W-1:0] s_d;

    ramif_banked_if #(.WIDTH(W), .DEPTH(D), .GROUPS(G)) bus_a ();
    ramif_banked_if #(.WIDTH(W), .DEPTH(D), .GROUPS(G)) bus_b ();
    ramif_banked_if #(.WIDTH(W), .DEPTH(D), .GROUPS(G)) bus_c ();

    assign bus_a.en_i = s_en;  assign bus_b.en_i = s_en;  assign bus_c.en_i = s_en;
    assign bus_a.we_i = s_we;  assign bus_b.we_i = s_we;  assign bus_c.we_i = s_we;
    assign bus_a.be_i = s_be;  assign bus_b.be_i = s_be;  assign bus_c.be_i = s_be;
    assign bus_a.addr_i = s_addr; assign bus_b.addr_i = s_addr; assign bus_c.addr_i = s_addr;
    assign bus_a.d_i = s_d;    assign bus_b.d_i = s_d;    assign bus_c.d_i = s_d;
    assign bus_a.clr_i = s_clr; assign bus_b.clr_i = s_clr; assign bus_c.clr_i = s_clr;

    ramif_banked #(.WIDTH(W), .DEPTH(D), .GROUP_W(GW), .READ_LAT(1), .CLEAR_ON_RESET(1),
                   .CLEAR_VAL(CV_A), .RAM_STYLE("distributed"))
        dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a.slave));
    ramif_banked #(.WIDTH(W), .DEPTH(D), .GROUP_W(GW), .READ_LAT(2), .CLEAR_ON_RESET(1),
                   .CLEAR_VAL(CV_B), .RAM_STYLE("block"))
        dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b.slave));
    ramif_banked #(.WIDTH(W), .DEPTH(D), .GROUP_W(GW), .READ_LAT(1), .CLEAR_ON_RESET(0),
                   .CLEAR_VAL(CV_C), .RAM_STYLE("distributed"))
        dut_c (.clk_i(clk), .rst_i(rst), .bus(bus_c.slave));

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference model state, one slot per instance
    int         lat_m [3];
    bit         cor_m [3];
    logic [W-1:0] cv_m [3];
    logic [W-1:0] m_mem [3][N];
    bit         m_clear [3];
    int         m_ptr [3];
    logic [W-1:0] m_d [3];
    bit         m_valid [3];
    // Read returns scheduled by edge number (modulo 4)
    logic [W-1:0] sched_d [3][4];
    bit         sched_v [3][4];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic en, input logic we, input logic [G-1:0] be,
                         input logic [D-1:0] addr, input logic [W-1:0] d, input logic clr);
        s_en = en; s_we = we; s_be = be; s_addr = addr; s_d = d; s_clr = clr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    // Apply one clock edge of the rules to the model.
    task automatic model_edge();
        int slot;
        int now;
        now = cyc % 4;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_clear[k] = cor_m[k];
                m_ptr[k]   = 0;
                m_d[k]     = '0;
                m_valid[k] = 1'b0;
                for (int s = 0; s < 4; s++) sched_v[k][s] = 1'b0;
            end else begin
                if (m_clear[k]) begin
                    m_mem[k][m_ptr[k]] = cv_m[k];
                    if (m_ptr[k] == N - 1) m_clear[k] = 1'b0;
                    m_ptr[k]++;
                end else if (s_clr) begin
                    m_clear[k] = 1'b1;
                    m_ptr[k]   = 0;
                end else if (s_en && s_we) begin
                    for (int g = 0; g < G; g++)
                        if (s_be[g]) m_mem[k][s_addr][g*GW +: GW] = s_d[g*GW +: GW];
                end else if (s_en) begin
                    slot = (cyc + lat_m[k] - 1) % 4;
                    sched_d[k][slot] = m_mem[k][s_addr];
                    sched_v[k][slot] = 1'b1;
                end
                m_valid[k] = 1'b0;
                if (sched_v[k][now]) begin
                    m_d[k]     = sched_d[k][now];
                    m_valid[k] = 1'b1;
                    sched_v[k][now] = 1'b0;
                end
            end
        end
    endtask

    task automatic cmp_inst(input string n, input int k, input logic [W-1:0] d,
                            input logic v, input logic b);
        check({n, "_valid"}, W'(v), W'(m_valid[k]));
        check({n, "_busy"}, W'(b), W'(m_clear[k]));
        if (!$isunknown(m_d[k])) check({n, "_dout"}, d, m_d[k]);
    endtask

    // One clock: model update at the edge, compare 1 time unit later,
    // return at the falling edge ready for the next drive.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cmp_inst("a", 0, bus_a.d_o, bus_a.valid_o, bus_a.busy_o);
        cmp_inst("b", 1, bus_b.d_o, bus_b.valid_o, bus_b.busy_o);
        cmp_inst("c", 2, bus_c.d_o, bus_c.valid_o, bus_c.busy_o);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        logic [W-1:0] lat2_d [5];
        bit           lat2_v [5];

        lat_m[0] = 1; lat_m[1] = 2; lat_m[2] = 1;
        cor_m[0] = 1'b1; cor_m[1] = 1'b1; cor_m[2] = 1'b0;
        cv_m[0] = CV_A; cv_m[1] = CV_B; cv_m[2] = CV_C;
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < N; a++) m_mem[k][a] = 'x;
            for (int s = 0; s < 4; s++) sched_v[k][s] = 1'b0;
            m_clear[k] = 1'b0; m_ptr[k] = 0; m_d[k] = '0; m_valid[k] = 1'b0;
        end
        lat2_d[0] = '0;         lat2_v[0] = 1'b0;
        lat2_d[1] = 32'h10;     lat2_v[1] = 1'b1;
        lat2_d[2] = 32'h20;     lat2_v[2] = 1'b1;
        lat2_d[3] = 32'h30;     lat2_v[3] = 1'b1;
        lat2_d[4] = 32'h30;     lat2_v[4] = 1'b0;

        // Reset
        rst = 1'b1;
        idle();
        tick();
        tick();
        check("rst_busy_a", W'(bus_a.busy_o), W'(1));
        check("rst_busy_c", W'(bus_c.busy_o), W'(0));
        check("rst_dout_b", bus_b.d_o, '0);
        rst = 1'b0;

        // Sweep length after reset; C accepts a read immediately
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus_a.busy_o) cnt++;
            if (i == 0) drive(1'b1, 1'b0, '0, D'(7), '0, 1'b0);
            else idle();
            tick();
            if (i == 0) check("c_first_read_valid", W'(bus_c.valid_o), W'(1));
        end
        check("busy_len_reset", cnt, 32);

        // Cleared contents at a few addresses
        for (int i = 0; i < 3; i++) begin
            logic [D-1:0] ra;
            ra = (i == 0) ? D'(0) : (i == 1) ? D'(17) : D'(31);
            drive(1'b1, 1'b0, 4'hF, ra, $urandom, 1'b0);
            tick();
            check("clear_fill_a", bus_a.d_o, CV_A);
            check("clear_fill_valid_a", W'(bus_a.valid_o), W'(1));
        end
        idle();
        tick();
        check("valid_single_a", W'(bus_a.valid_o), W'(0));

        // Group-masked write merge
        drive(1'b1, 1'b1, 4'b1111, D'(3), 32'h1122_3344, 1'b0); tick();
        drive(1'b1, 1'b1, 4'b0101, D'(3), 32'hFFFF_FFFF, 1'b0); tick();
        drive(1'b1, 1'b0, 4'b0000, D'(3), '0, 1'b0);            tick();
        check("be_merge_a", bus_a.d_o, 32'h11FF_33FF);
        idle();
        tick();
        check("be_pulse_a", W'(bus_a.valid_o), W'(0));

        // Back-to-back reads through the 2-cycle pipeline
        drive(1'b1, 1'b1, 4'hF, D'(0), 32'h10, 1'b0); tick();
        drive(1'b1, 1'b1, 4'hF, D'(1), 32'h20, 1'b0); tick();
        drive(1'b1, 1'b1, 4'hF, D'(2), 32'h30, 1'b0); tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b1, 1'b0, '0, D'(i), '0, 1'b0);
            else idle();
            tick();
            check("lat2_valid_b", W'(bus_b.valid_o), W'(lat2_v[i]));
            if (i > 0) check("lat2_data_b", bus_b.d_o, lat2_d[i]);
        end

        // Clear request colliding with a write; in-flight read still returns
        drive(1'b1, 1'b0, '0, D'(2), '0, 1'b0); tick();
        drive(1'b1, 1'b1, 4'hF, D'(5), 32'hDEAD_BEEF, 1'b1); tick();
        check("inflight_valid_b", W'(bus_b.valid_o), W'(1));
        check("inflight_data_b", bus_b.d_o, 32'h30);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus_a.busy_o) cnt++;
            if (i == 10) drive(1'b1, 1'b1, 4'hF, D'(9), 32'h1234_5678, 1'b0);
            else if (i == 20) drive(1'b1, 1'b0, '0, D'(4), '0, 1'b1);
            else idle();
            tick();
        end
        check("busy_len_clr", cnt, 32);
        drive(1'b1, 1'b0, '0, D'(5), '0, 1'b0); tick();
        check("clr_drop_wr5_a", bus_a.d_o, CV_A);
        check("clr_drop_wr5_c", bus_c.d_o, CV_C);
        drive(1'b1, 1'b0, '0, D'(9), '0, 1'b0); tick();
        check("clr_drop_wr9_a", bus_a.d_o, CV_A);

        // Reset in the middle of a sweep
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1); tick();
        idle();
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_dout_a", bus_a.d_o, '0);
        check("rst_mid_valid_a", W'(bus_a.valid_o), W'(0));
        check("rst_mid_busy_a", W'(bus_a.busy_o), W'(1));
        check("rst_mid_busy_c", W'(bus_c.busy_o), W'(0));
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus_a.busy_o) cnt++;
            tick();
        end
        check("busy_len_restart", cnt, 32);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), G'($urandom),
                  D'($urandom), $urandom, $urandom_range(0, 59) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ramif_banked.md
Name: ramif_banked

Overview:
- Parametrised single-port sample-memory wrapper for the logIP capture path, successor to the fixed LUT/BRAM RAM interface.
- Infers the memory behaviourally; the synthesis style is selected by parameter, with no vendor IP.
- Adds per-group (channel-group) write enables, a selectable read latency with a valid strobe, and a built-in clear engine that fills the array after reset or on request.
- Sits between the capture sampler/readback controller and storage.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of GROUP_W.
- DEPTH, 5, address width in bits; entries = 2**DEPTH.
- GROUP_W, 8, bits per channel group; GROUPS = WIDTH/GROUP_W.
- READ_LAT, 1, read latency in cycles; legal values are 1 or 2 (2 adds an output register).
- CLEAR_ON_RESET, 1, 1 = run the clear engine after reset; 0 = enter IDLE directly.
- CLEAR_VAL, 0, WIDTH-bit fill value written by the clear engine.
- RAM_STYLE, "distributed", synthesis attribute string; "distributed" or "block".

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous reset, active-high.
- en_i  input  1  access enable.
- we_i  input  1  1 = write, 0 = read (qualified by en_i).
- be_i  input  GROUPS  per-group write enable.
- addr_i  input  DEPTH  word address.
- d_i  input  WIDTH  write data.
- d_o  output  WIDTH  read data; holds its value between reads.
- valid_o  output  1  one-cycle pulse, asserted when d_o carries new read data.
- clr_i  input  1  start a clear sweep (level, sampled in IDLE).
- busy_o  output  1  clear sweep in progress; accesses are ignored.

Behaviour:
- Elaboration: raise $error if WIDTH % GROUP_W != 0 or READ_LAT is not in {1,2}.
- Reset (rst_i=1 at an edge):
  - d_o=0, valid_o=0, read pipeline cleared, clear pointer=0.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - busy_o=CLEAR_ON_RESET.
  - Memory contents are not otherwise reset.
- FSM states IDLE and CLEAR.
  - IDLE -> CLEAR when clr_i=1; the pointer loads 0.
  - In CLEAR, each edge writes CLEAR_VAL to mem[ptr] and increments ptr.
  - The edge that writes ptr=2**DEPTH-1 moves to IDLE.
  - busy_o is registered and equals (state==CLEAR): high for exactly 2**DEPTH cycles.
- Clear priority and interaction:
  - clr_i with en_i in the same IDLE cycle: clear wins and the access is dropped.
  - clr_i during CLEAR is ignored (no restart).
  - Reset during CLEAR restarts the sweep from 0 (when CLEAR_ON_RESET=1) or aborts it (when 0).
  - During CLEAR, en_i is ignored: no writes, no new reads.
  - Reads already in flight (READ_LAT=2) still complete with their valid_o pulse.
- Write (IDLE, en_i=1, we_i=1):
  - At the edge, mem[addr_i] group g takes d_i group g for each g with be_i[g]=1; other groups are unchanged.
  - be_i=0 gives a no-op.
  - No valid_o; d_o holds.
- Read (IDLE, en_i=1, we_i=0):
  - Array read is registered at the edge.
  - READ_LAT=1: d_o/valid_o update at edge N+1 relative to the request edge N.
  - READ_LAT=2: update at edge N+2.
  - Fully pipelined: back-to-back reads produce back-to-back valid_o pulses in order.
  - be_i is ignored for reads.
- Read-after-write to the same address on the next cycle returns the new data (the array is updated at the write edge).
- en_i=0: no array access; d_o holds; valid_o=0 unless an in-flight read completes.
- Address wrap: the clear pointer is DEPTH bits and the sweep terminates at the last entry; there is no wrap into a second pass.

Test Plan (WIDTH=32, DEPTH=5, GROUP_W=8 unless noted):
- Reset with CLEAR_ON_RESET=1, CLEAR_VAL=32'hA5A5_A5A5 -> busy_o high for exactly 32 cycles; afterwards reading addresses 0, 17 and 31 all return A5A5_A5A5 with valid_o one cycle after the request.
- Write 0x1122_3344 to address 3 with be_i=4'b1111, then write 0xFFFF_FFFF to address 3 with be_i=4'b0101, then read address 3 -> d_o=0x11FF_33FF; valid_o is a single pulse.
- READ_LAT=2: back-to-back reads of addresses 0, 1, 2 (holding 0x10, 0x20, 0x30) -> valid_o high for three consecutive cycles starting two edges after the first request; data arrives in order; d_o holds 0x30 afterwards.
- clr_i asserted together with a write of 0xDEAD_BEEF to address 5 -> write dropped, busy_o high for 32 cycles, address 5 reads CLEAR_VAL; a write attempted mid-sweep to address 9 also has no effect.
- rst_i pulsed at sweep cycle 10 -> busy_o stays high, sweep restarts, busy_o falls 32 cycles after reset release; valid_o=0 and d_o=0 at reset.
- CLEAR_ON_RESET=0 -> busy_o=0 immediately after reset; a read is accepted the first cycle after reset.
